// File: rtl/eth_pkg.sv
// Shared types for the receive path: byte type, frame length default and FSM state encodings.
package eth_pkg;

    typedef logic [7:0] byte_t;

    localparam int MAX_FRAME_LEN_DEF = 1518;

    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_DISCARD} wr_state_e;
    typedef enum logic {R_IDLE, R_STREAM} rd_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_len_fifo.sv
// Synchronous FIFO of committed frame lengths; head is visible combinationally on dout.
module frame_len_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign full  = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign empty = (wp == rp);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward RX frame buffer: speculative write with commit/rollback, replay of committed frames.
// Define RX_BUF_STATS_EN to build the saturating drop/overflow counters; otherwise both read 0.
module rx_frame_buffer
    import eth_pkg::*;
#(
    parameter int DEPTH         = 2048,
    parameter int MAX_FRAMES    = 8,
    parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF
) (
    input  logic        rx_clk,
    input  logic        rst_n,
    input  byte_t       in_data,
    input  logic        in_wr_en,
    input  logic        in_frame_valid,
    input  logic        in_frame_err,
    output byte_t       out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] out_len,
    output logic [15:0] drop_cnt,
    output logic [15:0] ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    byte_t       mem [DEPTH];
    ptr_t        wr_spec, wr_commit, rd, wr_spec_n, wr_commit_n, rd_addr;
    logic [15:0] len, len_n, len_base, push_len, rem, fifo_dout;
    wr_state_e   w_state, w_next;
    rd_state_e   r_state, r_next;
    logic        full, can_wr, do_wr, has_bytes, mem_we, push, pop, hs;
    logic        drop_ev, ovf_ev, fifo_full, fifo_empty;

    // Full: speculative writer has lapped the reader by exactly DEPTH bytes.
    assign full      = (wr_spec ^ rd) == {1'b1, {AW{1'b0}}};
    assign len_base  = (w_state == W_IDLE) ? 16'd0 : len;
    assign can_wr    = !full && (int'(len_base) < MAX_FRAME_LEN);
    assign do_wr     = in_wr_en && can_wr;
    assign has_bytes = (w_state == W_ACTIVE) || in_wr_en;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            wr_spec   <= '0;
            wr_commit <= '0;
            len       <= '0;
        end else begin
            w_state   <= w_next;
            wr_spec   <= wr_spec_n;
            wr_commit <= wr_commit_n;
            len       <= len_n;
        end
    end

    always_comb begin
        w_next      = w_state;
        wr_spec_n   = wr_spec;
        wr_commit_n = wr_commit;
        len_n       = len;
        mem_we      = 1'b0;
        push        = 1'b0;
        push_len    = '0;
        drop_ev     = 1'b0;
        ovf_ev      = 1'b0;
        unique case (w_state)
            W_IDLE, W_ACTIVE: begin
                if (do_wr) begin
                    mem_we    = 1'b1;
                    wr_spec_n = wr_spec + 1'b1;
                    len_n     = len_base + 16'd1;
                    w_next    = W_ACTIVE;
                end
                if (in_wr_en && !can_wr) begin
                    // The byte that did not fit may itself carry the status.
                    if (in_frame_err || in_frame_valid) begin
                        wr_spec_n = wr_commit;
                        len_n     = '0;
                        w_next    = W_IDLE;
                        drop_ev   = 1'b1;
                        ovf_ev    = !in_frame_err;
                    end else begin
                        w_next = W_DISCARD;
                    end
                end else if (has_bytes && in_frame_err) begin
                    wr_spec_n = wr_commit;
                    len_n     = '0;
                    w_next    = W_IDLE;
                    drop_ev   = 1'b1;
                end else if (has_bytes && in_frame_valid) begin
                    if (!fifo_full) begin
                        wr_commit_n = wr_spec_n;
                        push        = 1'b1;
                        push_len    = len_n;
                    end else begin
                        wr_spec_n = wr_commit;
                        drop_ev   = 1'b1;
                        ovf_ev    = 1'b1;
                    end
                    len_n  = '0;
                    w_next = W_IDLE;
                end
            end
            W_DISCARD: begin
                if (in_frame_err || in_frame_valid) begin
                    wr_spec_n = wr_commit;
                    len_n     = '0;
                    w_next    = W_IDLE;
                    drop_ev   = 1'b1;
                    ovf_ev    = 1'b1;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (mem_we) mem[wr_spec[AW-1:0]] <= in_data;
    end

    frame_len_fifo #(.DEPTH(MAX_FRAMES), .W(16)) u_len_fifo (
        .clk   (rx_clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_len),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hs       = out_valid && out_ready;
    assign out_last = out_valid && (rem == 16'd1);
    // Look one byte ahead on a handshake so a held-high ready streams without bubbles.
    assign rd_addr  = hs ? rd + 1'b1 : rd;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        pop    = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    r_next = R_STREAM;
                end
            end
            R_STREAM: begin
                if (hs && out_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd        <= '0;
            rem       <= '0;
            out_len   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_data <= mem[rd_addr[AW-1:0]];
            if (pop) begin
                out_len <= fifo_dout;
                rem     <= fifo_dout;
            end
            if (hs) begin
                rd  <= rd + 1'b1;
                rem <= rem - 16'd1;
                if (out_last) out_valid <= 1'b0;
            end else if (r_state == R_STREAM) begin
                out_valid <= 1'b1;
            end
        end
    end

`ifdef RX_BUF_STATS_EN
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (drop_ev) drop_cnt <= sat_inc(drop_cnt);
            if (ovf_ev)  ovf_cnt  <= sat_inc(ovf_cnt);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = drop_ev | ovf_ev;
    assign drop_cnt     = '0;
    assign ovf_cnt      = '0;
`endif

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Randomized self-checking bench: a queue model of committed frames against the default-depth and a 64-byte instance.
module tb_rx_frame_buffer;
    import eth_pkg::*;

`ifdef RX_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        rx_clk = 1'b0;
    logic        rst_n;
    byte_t       in_data;
    logic        in_wr_en, in_frame_valid, in_frame_err;
    logic        rdy_a, rdy_s;
    byte_t       a_data, s_data;
    logic        a_valid, a_last, s_valid, s_last;
    logic [15:0] a_len, a_drop, a_ovf, s_len, s_drop, s_ovf;

    int checks = 0;
    int errors = 0;
    int exp_drop;

    byte_t       ad[$], sd[$], ed[$];
    bit          al[$], sl[$], el[$];
    logic [15:0] an[$], sn[$], en[$];

    always #5 rx_clk = ~rx_clk;

    rx_frame_buffer dut (
        .rx_clk(rx_clk), .rst_n(rst_n), .in_data(in_data), .in_wr_en(in_wr_en),
        .in_frame_valid(in_frame_valid), .in_frame_err(in_frame_err),
        .out_data(a_data), .out_valid(a_valid), .out_ready(rdy_a), .out_last(a_last),
        .out_len(a_len), .drop_cnt(a_drop), .ovf_cnt(a_ovf)
    );

    rx_frame_buffer #(.DEPTH(64)) dut_s (
        .rx_clk(rx_clk), .rst_n(rst_n), .in_data(in_data), .in_wr_en(in_wr_en),
        .in_frame_valid(in_frame_valid), .in_frame_err(in_frame_err),
        .out_data(s_data), .out_valid(s_valid), .out_ready(rdy_s), .out_last(s_last),
        .out_len(s_len), .drop_cnt(s_drop), .ovf_cnt(s_ovf)
    );

    // Accepted bytes are captured mid-cycle; the transfer completes at the following rising edge.
    always @(negedge rx_clk) begin
        if (rst_n === 1'b1) begin
            if (a_valid && rdy_a) begin ad.push_back(a_data); al.push_back(a_last); an.push_back(a_len); end
            if (s_valid && rdy_s) begin sd.push_back(s_data); sl.push_back(s_last); sn.push_back(s_len); end
        end
    end

    task automatic tick;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic do_reset(input logic ra, input logic rs);
        rst_n = 1'b0; in_data = '0; in_wr_en = 0; in_frame_valid = 0; in_frame_err = 0;
        rdy_a = ra; rdy_s = rs;
        tick; tick;
        ad.delete(); al.delete(); an.delete(); sd.delete(); sl.delete(); sn.delete();
        ed.delete(); el.delete(); en.delete();
        exp_drop = 0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic rand_frame(input int n, output byte_t fr[$]);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(byte_t'($urandom));
    endtask

    task automatic expect_frame(input byte_t fr[$]);
        for (int i = 0; i < fr.size(); i++) begin
            ed.push_back(fr[i]); el.push_back(i == fr.size() - 1); en.push_back(16'(fr.size()));
        end
    endtask

    // good: in_frame_valid with the last byte; bad: in_frame_err with the last byte or (sep) one cycle later.
    task automatic send_frame(input byte_t fr[$], input bit good, input bit sep);
        for (int i = 0; i < fr.size(); i++) begin
            in_data = fr[i]; in_wr_en = 1'b1;
            in_frame_valid = good && (i == fr.size() - 1);
            in_frame_err   = !good && !sep && (i == fr.size() - 1);
            tick;
        end
        in_wr_en = 0; in_frame_valid = 0; in_frame_err = 0;
        if (!good && sep) begin in_frame_err = 1'b1; tick; in_frame_err = 1'b0; end
    endtask

    task automatic wait_out(input int budget);
        for (int c = 0; c < budget && ad.size() < ed.size(); c++) tick;
        repeat (8) tick;
    endtask

    task automatic test_reset;
        do_reset(1'b1, 1'b1);
        checks++;
        if ({a_valid, a_last, a_data, a_len, a_drop, a_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_a got v%b l%b d%h len%0d drop%0d ovf%0d want all 0", a_valid, a_last, a_data, a_len, a_drop, a_ovf);
        end
        checks++;
        if ({s_valid, s_last, s_data, s_len, s_drop, s_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_s got v%b l%b d%h len%0d drop%0d ovf%0d want all 0", s_valid, s_last, s_data, s_len, s_drop, s_ovf);
        end
    endtask

    task automatic test_good_frame;
        byte_t f[$];
        logic [2:0] v;
        do_reset(1'b1, 1'b1);
        rand_frame(64, f); expect_frame(f);
        send_frame(f, 1'b1, 1'b0);
        v[0] = a_valid; tick; v[1] = a_valid; tick; v[2] = a_valid;
        checks++;
        if (v !== 3'b100) begin errors++; $display("FAIL good_latency got valid(E0,E1,E2)=%b%b%b want 001", v[0], v[1], v[2]); end
        wait_out(300);
        checks++;
        if (ad.size() !== ed.size()) begin errors++; $display("FAIL good_count got %0d want %0d", ad.size(), ed.size()); end
        else foreach (ed[i]) begin
            checks++;
            if ({ad[i], al[i], an[i]} !== {ed[i], el[i], en[i]}) begin
                errors++; $display("FAIL good_byte[%0d] got %h/%b/%0d want %h/%b/%0d", i, ad[i], al[i], an[i], ed[i], el[i], en[i]);
            end
        end
    endtask

    task automatic test_crc_drop;
        byte_t f[$];
        do_reset(1'b1, 1'b1);
        rand_frame(100, f); send_frame(f, 1'b0, 1'b0); exp_drop++;
        rand_frame(60, f); expect_frame(f); send_frame(f, 1'b1, 1'b0);
        wait_out(400);
        checks++;
        if (ad.size() !== ed.size()) begin errors++; $display("FAIL crc_count got %0d want %0d", ad.size(), ed.size()); end
        else foreach (ed[i]) begin
            checks++;
            if ({ad[i], al[i], an[i]} !== {ed[i], el[i], en[i]}) begin
                errors++; $display("FAIL crc_byte[%0d] got %h/%b/%0d want %h/%b/%0d", i, ad[i], al[i], an[i], ed[i], el[i], en[i]);
            end
        end
        checks++;
        if ({a_drop, a_ovf} !== {(STATS ? 16'(exp_drop) : 16'd0), 16'd0}) begin
            errors++; $display("FAIL crc_counters got drop %0d ovf %0d want drop %0d ovf 0", a_drop, a_ovf, STATS ? exp_drop : 0);
        end
    endtask

    task automatic test_mid_err;
        byte_t f[$];
        do_reset(1'b1, 1'b1);
        rand_frame(10, f); send_frame(f, 1'b0, 1'b1); exp_drop++;
        rand_frame(64, f); expect_frame(f); send_frame(f, 1'b1, 1'b0);
        wait_out(400);
        checks++;
        if (ad.size() !== ed.size()) begin errors++; $display("FAIL miderr_count got %0d want %0d", ad.size(), ed.size()); end
        else foreach (ed[i]) begin
            checks++;
            if ({ad[i], al[i], an[i]} !== {ed[i], el[i], en[i]}) begin
                errors++; $display("FAIL miderr_byte[%0d] got %h/%b/%0d want %h/%b/%0d", i, ad[i], al[i], an[i], ed[i], el[i], en[i]);
            end
        end
        checks++;
        if (a_drop !== (STATS ? 16'(exp_drop) : 16'd0)) begin
            errors++; $display("FAIL miderr_drop got %0d want %0d", a_drop, STATS ? exp_drop : 0);
        end
    endtask

    task automatic test_overflow;
        byte_t f1[$], f2[$], f3[$];
        do_reset(1'b0, 1'b0);
        rand_frame(40, f1); rand_frame(40, f2); rand_frame(20, f3);
        expect_frame(f1);
        send_frame(f1, 1'b1, 1'b0);
        send_frame(f2, 1'b1, 1'b0);
        repeat (5) tick;
        checks++;
        if (sd.size() !== 0) begin errors++; $display("FAIL ovf_stalled got %0d bytes want 0", sd.size()); end
        checks++;
        if ({s_drop, s_ovf} !== (STATS ? {16'd1, 16'd1} : 32'd0)) begin
            errors++; $display("FAIL ovf_counters got drop %0d ovf %0d want %0d/%0d", s_drop, s_ovf, STATS, STATS);
        end
        rdy_s = 1'b1;
        for (int c = 0; c < 300 && sd.size() < 40; c++) tick;
        repeat (8) tick;
        expect_frame(f3);
        send_frame(f3, 1'b1, 1'b0);
        for (int c = 0; c < 300 && sd.size() < ed.size(); c++) tick;
        repeat (8) tick;
        checks++;
        if (sd.size() !== ed.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", sd.size(), ed.size()); end
        else foreach (ed[i]) begin
            checks++;
            if ({sd[i], sl[i], sn[i]} !== {ed[i], el[i], en[i]}) begin
                errors++; $display("FAIL ovf_byte[%0d] got %h/%b/%0d want %h/%b/%0d", i, sd[i], sl[i], sn[i], ed[i], el[i], en[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        byte_t f1[$], f2[$];
        do_reset(1'b0, 1'b1);
        rand_frame(64, f1); rand_frame(64, f2);
        expect_frame(f1); expect_frame(f2);
        fork
            begin
                send_frame(f1, 1'b1, 1'b0);
                send_frame(f2, 1'b1, 1'b0);
            end
            begin
                bit pv, pr;
                byte_t pd;
                pv = 1'b0; pr = 1'b1; pd = '0;
                for (int c = 0; c < 2000 && ad.size() < 128; c++) begin
                    if (pv && !pr) begin
                        checks++;
                        if (a_valid !== 1'b1 || a_data !== pd) begin
                            errors++; $display("FAIL stall_hold got v%b d%h want v1 d%h", a_valid, a_data, pd);
                        end
                    end
                    rdy_a = ~rdy_a;
                    pv = a_valid; pd = a_data; pr = rdy_a;
                    tick;
                end
            end
        join
        rdy_a = 1'b1;
        repeat (8) tick;
        checks++;
        if (ad.size() !== ed.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", ad.size(), ed.size()); end
        else foreach (ed[i]) begin
            checks++;
            if ({ad[i], al[i], an[i]} !== {ed[i], el[i], en[i]}) begin
                errors++; $display("FAIL b2b_byte[%0d] got %h/%b/%0d want %h/%b/%0d", i, ad[i], al[i], an[i], ed[i], el[i], en[i]);
            end
        end
    endtask

    task automatic test_random;
        bit w_done;
        do_reset(1'b0, 1'b1);
        w_done = 1'b0;
        fork
            begin
                byte_t f[$];
                for (int b = 0; b < 3; b++) begin
                    int nf;
                    nf = $urandom_range(2, 6);
                    for (int k = 0; k < nf; k++) begin
                        int n;
                        bit good;
                        n = $urandom_range(1, 200);
                        good = ($urandom_range(0, 3) != 0);
                        if (!good && n < 2) n = 2;
                        rand_frame(n, f);
                        if (good) expect_frame(f); else exp_drop++;
                        send_frame(f, good, 1'($urandom_range(0, 1)));
                        repeat ($urandom_range(0, 3)) begin
                            // Status with no bytes pending must be ignored.
                            if ($urandom_range(0, 2) == 0) begin
                                in_frame_valid = 1'($urandom_range(0, 1));
                                in_frame_err   = !in_frame_valid;
                            end
                            tick;
                            in_frame_valid = 1'b0; in_frame_err = 1'b0;
                        end
                    end
                    for (int c = 0; c < 6000 && ad.size() < ed.size(); c++) tick;
                end
                w_done = 1'b1;
            end
            begin
                for (int c = 0; c < 25000 && !(w_done && ad.size() >= ed.size()); c++) begin
                    rdy_a = 1'($urandom_range(0, 1));
                    tick;
                end
                rdy_a = 1'b1;
            end
        join
        repeat (8) tick;
        checks++;
        if (ad.size() !== ed.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", ad.size(), ed.size()); end
        else foreach (ed[i]) begin
            checks++;
            if ({ad[i], al[i], an[i]} !== {ed[i], el[i], en[i]}) begin
                errors++; $display("FAIL rand_byte[%0d] got %h/%b/%0d want %h/%b/%0d", i, ad[i], al[i], an[i], ed[i], el[i], en[i]);
            end
        end
        checks++;
        if ({a_drop, a_ovf} !== {(STATS ? 16'(exp_drop) : 16'd0), 16'd0}) begin
            errors++; $display("FAIL rand_counters got drop %0d ovf %0d want drop %0d ovf 0", a_drop, a_ovf, STATS ? exp_drop : 0);
        end
    endtask

    task automatic test_reset_mid;
        byte_t f[$];
        do_reset(1'b0, 1'b1);
        rand_frame(12, f); send_frame(f, 1'b0, 1'b0);
        rand_frame(30, f); send_frame(f, 1'b1, 1'b0);
        repeat (4) tick;
        checks++;
        if ({a_valid, a_len} !== {1'b1, 16'd30}) begin
            errors++; $display("FAIL rstmid_pre got v%b len%0d want v1 len30", a_valid, a_len);
        end
        rand_frame(20, f);
        for (int i = 0; i < 19; i++) begin in_data = f[i]; in_wr_en = 1'b1; tick; end
        in_data = f[19];
        rst_n = 1'b0;
        @(negedge rx_clk);
        checks++;
        if ({a_valid, a_last, a_data, a_len, a_drop, a_ovf} !== '0) begin
            errors++;
            $display("FAIL rstmid_out got v%b l%b d%h len%0d drop%0d ovf%0d want all 0", a_valid, a_last, a_data, a_len, a_drop, a_ovf);
        end
        in_wr_en = 1'b0;
        tick;
        ad.delete(); al.delete(); an.delete(); ed.delete(); el.delete(); en.delete();
        rst_n = 1'b1;
        tick;
        rdy_a = 1'b1;
        rand_frame(50, f); expect_frame(f); send_frame(f, 1'b1, 1'b0);
        wait_out(400);
        checks++;
        if (ad.size() !== ed.size()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", ad.size(), ed.size()); end
        else foreach (ed[i]) begin
            checks++;
            if ({ad[i], al[i], an[i]} !== {ed[i], el[i], en[i]}) begin
                errors++; $display("FAIL rstmid_byte[%0d] got %h/%b/%0d want %h/%b/%0d", i, ad[i], al[i], an[i], ed[i], el[i], en[i]);
            end
        end
        checks++;
        if (a_drop !== 16'd0) begin errors++; $display("FAIL rstmid_drop got %0d want 0", a_drop); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_crc_drop;
        test_mid_err;
        test_overflow;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
